// File: rtl/sm_rocc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sm_rocc_pkg
// Brief    : RoCC command field layout, custom-0 opcode and pack/unpack helpers.
// Revision : 1.0 - initial release
// ============================================================================
package sm_rocc_pkg;

  localparam int FUNCT_LSB  = 25;
  localparam int FUNCT_W    = 7;
  localparam int RS2_LSB    = 20;
  localparam int RS2_W      = 5;
  localparam int RS1_LSB    = 15;
  localparam int RS1_W      = 5;
  localparam int XD_BIT     = 14;
  localparam int XS1_BIT    = 13;
  localparam int XS2_BIT    = 12;
  localparam int RD_LSB     = 7;
  localparam int RD_W       = 5;
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 7;

  localparam int REG_W    = 5;
  localparam int NUM_REGS = 32;

  localparam logic [OPCODE_W-1:0] CUSTOM0_OPCODE = 7'h0B;

  typedef logic [31:0] inst_t;

  // Response messages carry rd above the data payload.
  function automatic int resp_rd_lsb(input int rd_data_bits);
    return rd_data_bits;
  endfunction

  function automatic inst_t pack_inst(
    input logic [FUNCT_W-1:0]  funct,
    input logic [RS2_W-1:0]    rs2,
    input logic [RS1_W-1:0]    rs1,
    input logic                xd,
    input logic                xs1,
    input logic                xs2,
    input logic [RD_W-1:0]     rd,
    input logic [OPCODE_W-1:0] opcode
  );
    inst_t w_inst;
    w_inst                           = '0;
    w_inst[FUNCT_LSB +: FUNCT_W]     = funct;
    w_inst[RS2_LSB +: RS2_W]         = rs2;
    w_inst[RS1_LSB +: RS1_W]         = rs1;
    w_inst[XD_BIT]                   = xd;
    w_inst[XS1_BIT]                  = xs1;
    w_inst[XS2_BIT]                  = xs2;
    w_inst[RD_LSB +: RD_W]           = rd;
    w_inst[OPCODE_LSB +: OPCODE_W]   = opcode;
    return w_inst;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm_rocc_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : sm_rocc_scoreboard
// Brief    : Per-register pending-writeback bits plus outstanding-response count.
// Revision : 1.0 - initial release
// ============================================================================
module sm_rocc_scoreboard
  import sm_rocc_pkg::*;
#(
  parameter int p_max_outstanding = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_set_en,
  input  logic [REG_W-1:0] i_set_rd,
  input  logic             i_clr_en,
  input  logic [REG_W-1:0] i_clr_rd,
  input  logic [REG_W-1:0] i_query_rs1,
  input  logic [REG_W-1:0] i_query_rs2,
  input  logic [REG_W-1:0] i_query_rd,
  input  logic [REG_W-1:0] i_query_resp_rd,
  output logic             o_hit_rs1,
  output logic             o_hit_rs2,
  output logic             o_hit_rd,
  output logic             o_hit_resp_rd,
  output logic             o_full,
  output logic [4:0]       o_outstanding
);

  localparam logic [4:0] c_max_outstanding = 5'(p_max_outstanding);

  logic [NUM_REGS-1:0] r_sb;
  logic [NUM_REGS-1:0] w_sb_next;
  logic [4:0]          r_count;

  // Set and clear never target the same rd: set needs the bit clear, clear needs it set.
  always_comb begin
    w_sb_next = r_sb;
    if (i_clr_en) w_sb_next[i_clr_rd] = 1'b0;
    if (i_set_en) w_sb_next[i_set_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sb    <= '0;
      r_count <= '0;
    end else begin
      r_sb <= w_sb_next;
      case ({i_set_en, i_clr_en})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_hit_rs1     = r_sb[i_query_rs1];
  assign o_hit_rs2     = r_sb[i_query_rs2];
  assign o_hit_rd      = r_sb[i_query_rd];
  assign o_hit_resp_rd = r_sb[i_query_resp_rd];
  assign o_full        = (r_count == c_max_outstanding);
  assign o_outstanding = r_count;

endmodule
`default_nettype wire

// File: rtl/sm_rocc_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : sm_rocc_cmd_issuer
// Brief    : Core-side RoCC initiator: packs issue requests into commands,
//            unpacks responses into writebacks, tracks pending rd registers.
//            Define SM_ROCC_TIMEOUT_EN to build the response watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module sm_rocc_cmd_issuer
  import sm_rocc_pkg::*;
#(
  parameter int                  p_rs1bits         = 32,
  parameter int                  p_rd_data_bits    = 32,
  parameter int                  p_max_outstanding = 4,
  parameter logic [OPCODE_W-1:0] p_opcode          = CUSTOM0_OPCODE,
  parameter int                  p_timeout_cycles  = 1024
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              req_val,
  output logic                              req_rdy,
  input  logic [FUNCT_W-1:0]                req_funct,
  input  logic [RS2_W-1:0]                  req_rs2,
  input  logic [RS1_W-1:0]                  req_rs1,
  input  logic [RD_W-1:0]                   req_rd,
  input  logic                              req_xd,
  input  logic                              req_xs1,
  input  logic                              req_xs2,
  input  logic [p_rs1bits-1:0]              req_rs1_data,
  output logic                              cmd_val,
  input  logic                              cmd_rdy,
  output logic [p_rs1bits+31:0]             cmd_msg,
  input  logic                              resp_val,
  output logic                              resp_rdy,
  input  logic [REG_W+p_rd_data_bits-1:0]   resp_msg,
  output logic                              wb_val,
  input  logic                              wb_rdy,
  output logic [REG_W-1:0]                  wb_rd,
  output logic [p_rd_data_bits-1:0]         wb_data,
  output logic                              busy,
  output logic [4:0]                        outstanding,
  output logic                              err_unexpected,
  output logic                              timeout_err
);

  localparam int c_rd_lsb = resp_rd_lsb(p_rd_data_bits);

  logic                      w_hit_rs1;
  logic                      w_hit_rs2;
  logic                      w_hit_rd;
  logic                      w_hit_resp_rd;
  logic                      w_full;
  logic [4:0]                w_outstanding;
  logic                      w_hazard;
  logic                      w_issue;
  logic                      w_resp_fire;
  logic                      w_sb_set;
  logic                      w_sb_clr;
  logic [REG_W-1:0]          w_resp_rd;
  logic [p_rd_data_bits-1:0] w_resp_data;

  logic                      r_cmd_val;
  logic [p_rs1bits+31:0]     r_cmd_msg;
  logic                      r_wb_val;
  logic [REG_W-1:0]          r_wb_rd;
  logic [p_rd_data_bits-1:0] r_wb_data;
  logic                      r_err_unexpected;

  assign w_resp_rd   = resp_msg[c_rd_lsb +: REG_W];
  assign w_resp_data = resp_msg[p_rd_data_bits-1:0];

  sm_rocc_scoreboard #(
    .p_max_outstanding (p_max_outstanding)
  ) u_scoreboard (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_set_en        (w_sb_set),
    .i_set_rd        (req_rd),
    .i_clr_en        (w_sb_clr),
    .i_clr_rd        (w_resp_rd),
    .i_query_rs1     (req_rs1),
    .i_query_rs2     (req_rs2),
    .i_query_rd      (req_rd),
    .i_query_resp_rd (w_resp_rd),
    .o_hit_rs1       (w_hit_rs1),
    .o_hit_rs2       (w_hit_rs2),
    .o_hit_rd        (w_hit_rd),
    .o_hit_resp_rd   (w_hit_resp_rd),
    .o_full          (w_full),
    .o_outstanding   (w_outstanding)
  );

  // Hazard looks at pre-edge scoreboard state, so a same-rd reissue waits one cycle.
  assign w_hazard = (req_xs1 && w_hit_rs1) ||
                    (req_xs2 && w_hit_rs2) ||
                    (req_xd  && (w_hit_rd || w_full));

  assign req_rdy     = (!r_cmd_val || cmd_rdy) && !w_hazard;
  assign w_issue     = req_val && req_rdy;
  assign resp_rdy    = !r_wb_val || wb_rdy;
  assign w_resp_fire = resp_val && resp_rdy;
  assign w_sb_set    = w_issue && req_xd;
  assign w_sb_clr    = w_resp_fire && w_hit_resp_rd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_val <= 1'b0;
      r_cmd_msg <= '0;
    end else if (w_issue) begin
      r_cmd_val <= 1'b1;
      r_cmd_msg <= {req_rs1_data,
                    pack_inst(req_funct, req_rs2, req_rs1, req_xd, req_xs1,
                              req_xs2, req_rd, p_opcode)};
    end else if (cmd_rdy) begin
      r_cmd_val <= 1'b0;
    end
  end

  // Unmatched responses are consumed and dropped; only the sticky flag records them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_val         <= 1'b0;
      r_wb_rd          <= '0;
      r_wb_data        <= '0;
      r_err_unexpected <= 1'b0;
    end else begin
      if (w_sb_clr) begin
        r_wb_val  <= 1'b1;
        r_wb_rd   <= w_resp_rd;
        r_wb_data <= w_resp_data;
      end else if (wb_rdy) begin
        r_wb_val  <= 1'b0;
      end
      if (w_resp_fire && !w_hit_resp_rd) begin
        r_err_unexpected <= 1'b1;
      end
    end
  end

`ifdef SM_ROCC_TIMEOUT_EN
  localparam logic [15:0] c_timeout_limit = 16'(p_timeout_cycles);

  logic [15:0] r_wdog;
  logic        r_timeout_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else if ((w_outstanding == 5'd0) || w_sb_clr) begin
      r_wdog <= '0;
    end else if (r_wdog != c_timeout_limit) begin
      r_wdog <= r_wdog + 16'd1;
      if ((r_wdog + 16'd1) == c_timeout_limit) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  assign cmd_val        = r_cmd_val;
  assign cmd_msg        = r_cmd_msg;
  assign wb_val         = r_wb_val;
  assign wb_rd          = r_wb_rd;
  assign wb_data        = r_wb_data;
  assign err_unexpected = r_err_unexpected;
  assign outstanding    = w_outstanding;
  assign busy           = (w_outstanding != 5'd0);

endmodule
`default_nettype wire

// File: tb/tb_sm_rocc_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_rocc_cmd_issuer
// Brief    : Vector table plus scoreboard bench for the RoCC command issuer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_rocc_cmd_issuer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_val, req_rdy;
  logic [6:0]  req_funct;
  logic [4:0]  req_rs2, req_rs1, req_rd;
  logic        req_xd, req_xs1, req_xs2;
  logic [31:0] req_rs1_data;
  logic        cmd_val, cmd_rdy;
  logic [63:0] cmd_msg;
  logic        resp_val, resp_rdy;
  logic [36:0] resp_msg;
  logic        wb_val, wb_rdy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
  logic [4:0]  outstanding;
  logic        err_unexpected, timeout_err;

  typedef struct {
    logic [6:0]  funct;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic        xd;
    logic        xs1;
    logic        xs2;
    logic [31:0] rs1_data;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t        vecs[4];
  logic [63:0] cmd_q[$];
  logic [36:0] wb_q[$];
  logic [31:0] m_pend;
  logic        toggle_en = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  sm_rocc_cmd_issuer #(
    .p_rs1bits         (32),
    .p_rd_data_bits    (32),
    .p_max_outstanding (4),
    .p_opcode          (7'h0B),
    .p_timeout_cycles  (8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_val        (req_val),
    .req_rdy        (req_rdy),
    .req_funct      (req_funct),
    .req_rs2        (req_rs2),
    .req_rs1        (req_rs1),
    .req_rd         (req_rd),
    .req_xd         (req_xd),
    .req_xs1        (req_xs1),
    .req_xs2        (req_xs2),
    .req_rs1_data   (req_rs1_data),
    .cmd_val        (cmd_val),
    .cmd_rdy        (cmd_rdy),
    .cmd_msg        (cmd_msg),
    .resp_val       (resp_val),
    .resp_rdy       (resp_rdy),
    .resp_msg       (resp_msg),
    .wb_val         (wb_val),
    .wb_rdy         (wb_rdy),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .busy           (busy),
    .outstanding    (outstanding),
    .err_unexpected (err_unexpected),
    .timeout_err    (timeout_err)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mk_inst(input logic [6:0] f, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [4:0] rd,
                                          input logic xd, input logic xs1, input logic xs2);
    return {f, r2, r1, xd, xs1, xs2, rd, 7'h0B};
  endfunction

  function automatic vec_t mk_vec(input logic [6:0] f, input logic [4:0] r2, input logic [4:0] r1,
                                  input logic [4:0] rd, input logic xd, input logic xs1,
                                  input logic xs2, input logic [31:0] data);
    vec_t v;
    v.funct = f; v.rs2 = r2; v.rs1 = r1; v.rd = rd;
    v.xd = xd; v.xs1 = xs1; v.xs2 = xs2; v.rs1_data = data;
    v.exp_inst = mk_inst(f, r2, r1, rd, xd, xs1, xs2);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: handshake never completed, required completion", name);
  endtask

  // Monitors: pop expected transfers when the DUT presents val&&rdy
  initial forever begin
    @(negedge clk);
    if (reset_n && cmd_val && cmd_rdy) begin
      if (cmd_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL cmd_extra: got %h, required no command", cmd_msg);
      end else begin
        chk("cmd_sb", cmd_msg, cmd_q.pop_front());
      end
    end
    if (reset_n && wb_val && wb_rdy) begin
      if (wb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL wb_extra: got rd %0d data %h, required no writeback", wb_rd, wb_data);
      end else begin
        chk("wb_sb", {27'd0, wb_rd, wb_data}, {27'd0, wb_q.pop_front()});
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (toggle_en) cmd_rdy = ~cmd_rdy;
  end

  // Called and returns at posedge+1.
  task automatic do_issue(input vec_t v);
    int cnt = 0;
    req_funct = v.funct; req_rs2 = v.rs2; req_rs1 = v.rs1; req_rd = v.rd;
    req_xd = v.xd; req_xs1 = v.xs1; req_xs2 = v.xs2; req_rs1_data = v.rs1_data;
    req_val = 1'b1;
    #1;
    while (!req_rdy && cnt < 50) begin
      @(posedge clk); #2;
      cnt++;
    end
    if (!req_rdy) begin
      note_fail("issue_timeout");
      @(posedge clk); #1;
      req_val = 1'b0;
      return;
    end
    @(posedge clk);
    cmd_q.push_back({v.rs1_data, v.exp_inst});
    if (v.xd) m_pend[v.rd] = 1'b1;
    #1;
    req_val = 1'b0;
  endtask

  task automatic send_resp(input logic [4:0] rd, input logic [31:0] data);
    int cnt = 0;
    resp_msg = {rd, data};
    resp_val = 1'b1;
    #1;
    while (!resp_rdy && cnt < 50) begin
      @(posedge clk); #2;
      cnt++;
    end
    if (!resp_rdy) begin
      note_fail("resp_timeout");
      @(posedge clk); #1;
      resp_val = 1'b0;
      return;
    end
    @(posedge clk);
    if (m_pend[rd]) begin
      wb_q.push_back({rd, data});
      m_pend[rd] = 1'b0;
    end
    #1;
    resp_val = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    req_val = 1'b0; req_funct = '0; req_rs2 = '0; req_rs1 = '0; req_rd = '0;
    req_xd = 1'b0; req_xs1 = 1'b0; req_xs2 = 1'b0; req_rs1_data = '0;
    cmd_rdy = 1'b1; resp_val = 1'b0; resp_msg = '0; wb_rdy = 1'b1; m_pend = '0;

    vecs[0] = '{7'd3,  5'd0,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0600428B};
    vecs[1] = '{7'h7F, 5'd31, 5'd31, 5'd31, 1'b0, 1'b1, 1'b1, 32'h00000000, 32'hFFFFBF8B};
    vecs[2] = '{7'h15, 5'd10, 5'd3,  5'd0,  1'b0, 1'b1, 1'b0, 32'h00000001, 32'h2AA1A00B};
    vecs[3] = '{7'h40, 5'd1,  5'd2,  5'd6,  1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h8011130B};

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("rst_cmd_val", 64'(cmd_val), 64'd0);
    chk("rst_wb_val", 64'(wb_val), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err", 64'(err_unexpected), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'd1);
    chk("rst_resp_rdy", 64'(resp_rdy), 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      do_issue(vecs[i]);
      chk("vec_cmd_val", 64'(cmd_val), 64'd1);
      chk("vec_cmd_msg", cmd_msg, {vecs[i].rs1_data, vecs[i].exp_inst});
    end
    chk("vec_outstanding", 64'(outstanding), 64'd1);
    chk("vec_busy", 64'(busy), 64'd1);

    // rs1 hazard on pending rd=5, released one cycle after its response
    req_funct = '0; req_rs2 = '0; req_rs1 = 5'd5; req_rd = '0; req_xd = 1'b0;
    req_xs1 = 1'b1; req_xs2 = 1'b0; req_rs1_data = 32'hCAFEF00D; req_val = 1'b1;
    #1 chk("haz_rdy0", 64'(req_rdy), 64'd0);
    @(posedge clk); #1;
    resp_msg = {5'd5, 32'h00001234}; resp_val = 1'b1;
    #1;
    chk("haz_rdy_during_resp", 64'(req_rdy), 64'd0);
    chk("haz_resp_rdy", 64'(resp_rdy), 64'd1);
    @(posedge clk);
    wb_q.push_back({5'd5, 32'h00001234});
    m_pend[5] = 1'b0;
    #1 resp_val = 1'b0;
    chk("wb_val", 64'(wb_val), 64'd1);
    chk("wb_rd", 64'(wb_rd), 64'd5);
    chk("wb_data", 64'(wb_data), 64'h1234);
    chk("resp_outstanding", 64'(outstanding), 64'd0);
    chk("resp_busy", 64'(busy), 64'd0);
    chk("haz_released", 64'(req_rdy), 64'd1);
    @(posedge clk);
    cmd_q.push_back({32'hCAFEF00D, mk_inst(7'd0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0)});
    #1 req_val = 1'b0;
    chk("haz_cmd_val", 64'(cmd_val), 64'd1);

    // Fill to the outstanding limit with cmd_rdy toggling
    toggle_en = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      do_issue(mk_vec(7'(r), 5'd0, 5'd0, 5'(r), 1'b1, 1'b0, 1'b0, 32'h1000 + 32'(r)));
    end
    req_rd = 5'd7; req_xd = 1'b1; req_xs1 = 1'b0; req_xs2 = 1'b0; req_val = 1'b1;
    #1 chk("full_stall0", 64'(req_rdy), 64'd0);
    repeat (2) @(posedge clk);
    #2 chk("full_stall1", 64'(req_rdy), 64'd0);
    chk("full_outstanding", 64'(outstanding), 64'd4);
    req_val = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    toggle_en = 1'b0;
    cmd_rdy = 1'b1;

    // Out-of-order responses; first writeback held by wb_rdy=0
    wb_rdy = 1'b0;
    send_resp(5'd3, 32'h00003333);
    chk("wbhold_val", 64'(wb_val), 64'd1);
    chk("wbhold_rd", 64'(wb_rd), 64'd3);
    chk("wbhold_resp_rdy", 64'(resp_rdy), 64'd0);
    @(posedge clk); #1;
    chk("wbhold_still", 64'(wb_val), 64'd1);
    wb_rdy = 1'b1;
    send_resp(5'd1, 32'h00001111);
    send_resp(5'd4, 32'h00004444);
    send_resp(5'd2, 32'h00002222);
    @(posedge clk); #1;
    chk("drain_outstanding", 64'(outstanding), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);

    // Response for a register that is not pending
    send_resp(5'd9, 32'h00009999);
    chk("unexp_wb_val", 64'(wb_val), 64'd0);
    chk("unexp_err", 64'(err_unexpected), 64'd1);
    chk("unexp_outstanding", 64'(outstanding), 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("unexp_err_sticky", 64'(err_unexpected), 64'd1);

    do_issue(mk_vec(7'h22, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h22));
`ifdef SM_ROCC_TIMEOUT_EN
    repeat (7) @(posedge clk);
    #1 chk("wdog_before", 64'(timeout_err), 64'd0);
    @(posedge clk);
    #1 chk("wdog_fired", 64'(timeout_err), 64'd1);
`else
    repeat (20) @(posedge clk);
    #1 chk("wdog_absent", 64'(timeout_err), 64'd0);
`endif

    // Asynchronous reset with both output registers held full
    cmd_rdy = 1'b0;
    wb_rdy = 1'b0;
    send_resp(5'd2, 32'h0000BEEF);
    do_issue(mk_vec(7'h08, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 32'h88));
    chk("pre_rst_cmd_val", 64'(cmd_val), 64'd1);
    chk("pre_rst_wb_val", 64'(wb_val), 64'd1);
    chk("pre_rst_outstanding", 64'(outstanding), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_cmd_val", 64'(cmd_val), 64'd0);
    chk("arst_cmd_msg", cmd_msg, 64'd0);
    chk("arst_wb_val", 64'(wb_val), 64'd0);
    chk("arst_wb_rd", 64'(wb_rd), 64'd0);
    chk("arst_wb_data", 64'(wb_data), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_outstanding", 64'(outstanding), 64'd0);
    chk("arst_err", 64'(err_unexpected), 64'd0);
    chk("arst_timeout", 64'(timeout_err), 64'd0);
    cmd_q.delete();
    wb_q.delete();
    m_pend = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    cmd_rdy = 1'b1;
    wb_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("post_rst_cmd_val", 64'(cmd_val), 64'd0);
    chk("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    chk("wb_q_empty", 64'(wb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
